// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/div, HI/LO registers, mfhi/mflo/mthi/mtlo.
// Optional accumulate ops (madd/maddu/msub/msubu) are compiled in with `define MDU_MADD_EN.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IntReq,
  input  logic [3:0]  MDUop,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUResult
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [3:0]  cnt;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic        p_wr;
  logic        issue;

  logic [63:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  logic        b_zero;
  logic [31:0] a_mag, b_mag, div_s, div_u;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        is_long;
  logic [3:0]  load_cnt;
  logic [63:0] calc;
  logic        calc_wr;

  // Start is the issue request; it is accepted only on an edge where Busy is low
  // and IntReq is low. A request seen while Busy is dropped, not queued.
  assign Busy  = (cnt != 4'd0);
  assign issue = Start & ~Busy & ~IntReq;

  always_comb begin
    a_sx   = {{32{A[31]}}, A};
    b_sx   = {{32{B[31]}}, B};
    a_zx   = {32'd0, A};
    b_zx   = {32'd0, B};
    prod_s = a_sx * b_sx;
    prod_u = a_zx * b_zx;

    // Signed divide on magnitudes, then restore signs; the divisor is forced
    // to 1 on divide-by-zero so the datapath never produces X.
    b_zero = (B == 32'd0);
    a_mag  = A[31] ? -A : A;
    b_mag  = B[31] ? -B : B;
    div_s  = b_zero ? 32'd1 : b_mag;
    div_u  = b_zero ? 32'd1 : B;
    q_mag  = a_mag / div_s;
    r_mag  = a_mag % div_s;
    q_s    = (A[31] ^ B[31]) ? -q_mag : q_mag;
    r_s    = A[31] ? -r_mag : r_mag;
    q_u    = A / div_u;
    r_u    = A % div_u;
  end

  always_comb begin
    is_long  = 1'b0;
    load_cnt = 4'd0;
    calc     = {HI, LO};
    calc_wr  = 1'b0;
    case (MDUop)
      OP_MULT:  begin is_long = 1'b1; load_cnt = MULT_N; calc = prod_s; calc_wr = 1'b1; end
      OP_MULTU: begin is_long = 1'b1; load_cnt = MULT_N; calc = prod_u; calc_wr = 1'b1; end
      OP_DIV:   begin is_long = 1'b1; load_cnt = DIV_N; calc = {r_s, q_s}; calc_wr = ~b_zero; end
      OP_DIVU:  begin is_long = 1'b1; load_cnt = DIV_N; calc = {r_u, q_u}; calc_wr = ~b_zero; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_long = 1'b1; load_cnt = MULT_N; calc = {HI, LO} + prod_s; calc_wr = 1'b1; end
      OP_MADDU: begin is_long = 1'b1; load_cnt = MULT_N; calc = {HI, LO} + prod_u; calc_wr = 1'b1; end
      OP_MSUB:  begin is_long = 1'b1; load_cnt = MULT_N; calc = {HI, LO} - prod_s; calc_wr = 1'b1; end
      OP_MSUBU: begin is_long = 1'b1; load_cnt = MULT_N; calc = {HI, LO} - prod_u; calc_wr = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      HI   <= 32'd0;
      LO   <= 32'd0;
      cnt  <= 4'd0;
      p_hi <= 32'd0;
      p_lo <= 32'd0;
      p_wr <= 1'b0;
    end else if (Busy) begin
      cnt <= cnt - 4'd1;
      // Commit on the last busy edge so HI/LO update as Busy falls.
      if (cnt == 4'd1 && p_wr) begin
        HI <= p_hi;
        LO <= p_lo;
      end
    end else if (issue) begin
      if (is_long) begin
        cnt  <= load_cnt;
        p_hi <= calc[63:32];
        p_lo <= calc[31:0];
        p_wr <= calc_wr;
      end else if (MDUop == OP_MTHI) begin
        HI <= A;
      end else if (MDUop == OP_MTLO) begin
        LO <= A;
      end
    end
  end

  always_comb begin
    MDUResult = 32'd0;
    if (MDUop == OP_MFHI) MDUResult = HI;
    else if (MDUop == OP_MFLO) MDUResult = LO;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed and random ops checked by a scoreboard against an arithmetic model.
// Build with `define MDU_MADD_EN to cover the accumulate ops.
module tb_e_mdu;

  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;

  logic        clk;
  logic        reset;
  logic        IntReq;
  logic [3:0]  MDUop;
  logic        Start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUResult;

  e_mdu #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
    .clk(clk), .reset(reset), .IntReq(IntReq), .MDUop(MDUop), .Start(Start),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO), .MDUResult(MDUResult)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- scoreboard state ----
  typedef struct packed {
    int          due;
    logic        kind;   // 0: {HI,LO}, 1: MDUResult
    logic [63:0] val;
  } rec_t;

  rec_t        exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  int          busy_from = 0;
  int          busy_until = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  function automatic void push(input int due, input logic kind, input logic [63:0] val);
    rec_t r;
    r.due = due; r.kind = kind; r.val = val;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].due > due) begin
        exp_q.insert(i, r);
        return;
      end
    end
    exp_q.push_back(r);
  endfunction

  function automatic void flush_from(input int from);
    rec_t keep[$];
    foreach (exp_q[i]) if (exp_q[i].due < from) keep.push_back(exp_q[i]);
    exp_q = keep;
  endfunction

  // ---- reference model: architectural result of one accepted op ----
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] old, output logic [63:0] nw, output int lat);
    longint      sa, sb, q, r;
    logic [63:0] ps, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = 64'(sa * sb);
    pu = {32'd0, a} * {32'd0, b};
    nw = old;
    lat = 0;
    case (op)
      4'd1: begin nw = ps; lat = MULT_C; end
      4'd2: begin nw = pu; lat = MULT_C; end
      4'd3: begin
        lat = DIV_C;
        if (b != 32'd0) begin
          q = sa / sb;
          r = sa % sb;
          nw = {r[31:0], q[31:0]};
        end
      end
      4'd4: begin
        lat = DIV_C;
        if (b != 32'd0) nw = {a % b, a / b};
      end
      4'd7: nw[63:32] = a;
      4'd8: nw[31:0] = a;
`ifdef MDU_MADD_EN
      4'd9:  begin nw = old + ps; lat = MULT_C; end
      4'd10: begin nw = old + pu; lat = MULT_C; end
      4'd11: begin nw = old - ps; lat = MULT_C; end
      4'd12: begin nw = old - pu; lat = MULT_C; end
`endif
      default: ;
    endcase
  endtask

  // ---- monitor ----
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_busy;
      rec_t r;
      exp_busy = (cyc >= busy_from) && (cyc < busy_until);
      n_chk++;
      if (Busy !== exp_busy) begin
        n_err++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, Busy, exp_busy);
      end
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        r = exp_q.pop_front();
        n_chk++;
        if (r.due != cyc) begin
          n_err++;
          $display("FAIL late_check cyc=%0d due=%0d", cyc, r.due);
        end else if (r.kind == 1'b0) begin
          if ({HI, LO} !== r.val) begin
            n_err++;
            $display("FAIL hilo cyc=%0d got=%h_%h exp=%h_%h", cyc, HI, LO, r.val[63:32], r.val[31:0]);
          end
        end else if (MDUResult !== r.val[31:0]) begin
          n_err++;
          $display("FAIL mduresult cyc=%0d op=%0d got=%h exp=%h", cyc, MDUop, MDUResult, r.val[31:0]);
        end
      end
    end
  end

  // ---- driver tasks ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic irq, output int e, output int lat, output logic [63:0] old);
    logic [63:0] nw;
    e = cyc + 1;
    old = {m_hi, m_lo};
    nw = old;
    lat = 0;
    if (!irq) model_op(op, a, b, old, nw, lat);
    MDUop = op; A = a; B = b; Start = 1'b1; IntReq = irq;
    push(e + lat - 1, 1'b0, old);
    push(e + lat, 1'b0, nw);
    if (lat > 0) begin
      busy_from = e;
      busy_until = e + lat;
    end
    {m_hi, m_lo} = nw;
  endtask

  task automatic wait_done(input int e, input int lat, input logic [63:0] old, input bit noise);
    int w = 0;
    while (cyc < e + lat) begin
      if (lat >= 3 && w == 0 && noise) begin
        // Requests while busy must be ignored, IntReq must not cancel the op.
        Start = 1'b1; MDUop = 4'($urandom_range(1, 12));
        A = $urandom; B = $urandom; IntReq = 1'($urandom_range(0, 1));
      end else if (lat >= 3 && w == 1) begin
        Start = 1'b0; IntReq = 1'b0; MDUop = 4'd6;
        push(cyc, 1'b1, {32'd0, old[31:0]});
      end else if (lat >= 3 && w == 2) begin
        MDUop = 4'd5;
        push(cyc, 1'b1, {32'd0, old[63:32]});
      end else begin
        Start = 1'b0; IntReq = 1'b0; MDUop = 4'd0;
      end
      w++;
      step();
    end
    Start = 1'b0; IntReq = 1'b0; MDUop = 4'd0;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic irq, input bit noise);
    int e, lat;
    logic [63:0] old;
    issue_op(op, a, b, irq, e, lat, old);
    step();
    Start = 1'b0; MDUop = 4'd0; IntReq = 1'b0;
    wait_done(e, lat, old, noise);
  endtask

  // ---- stimulus ----
  initial begin
    int e, lat, r;
    logic [63:0] old;
    logic [31:0] ra, rb;
    logic [3:0]  rop;

    reset = 1'b1; Start = 1'b0; IntReq = 1'b0; MDUop = 4'd0; A = 32'd0; B = 32'd0;
    repeat (3) step();
    reset = 1'b0;
    mon_en = 1'b1;
    push(cyc, 1'b0, 64'd0);
    push(cyc, 1'b1, 64'd0);
    step();

    do_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    do_op(4'd4, 32'd7, 32'd2, 1'b0, 1'b0);
    do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);

    do_op(4'd7, 32'h11, 32'd0, 1'b0, 1'b0);
    do_op(4'd8, 32'h22, 32'd0, 1'b0, 1'b0);
    do_op(4'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

    do_op(4'd7, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
    do_op(4'd7, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    MDUop = 4'd5;
    push(cyc, 1'b1, {32'd0, m_hi});
    step();
    MDUop = 4'd0;

    do_op(4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    do_op(4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    do_op(4'd9, 32'd1, 32'd1, 1'b0, 1'b0);

    // Reset mid-operation: pending multu result must be discarded.
    issue_op(4'd2, $urandom, $urandom, 1'b0, e, lat, old);
    step();
    Start = 1'b0; MDUop = 4'd0; IntReq = 1'b1;
    step();
    IntReq = 1'b0; reset = 1'b1;
    r = cyc + 1;
    flush_from(r);
    m_hi = 32'd0; m_lo = 32'd0;
    push(r, 1'b0, 64'd0);
    push(e + lat, 1'b0, 64'd0);
    if (busy_until > r) busy_until = r;
    step();
    reset = 1'b0;
    while (cyc <= e + lat) step();

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      do_op(rop, ra, rb, ($urandom_range(0, 3) == 0), 1'b1);
    end

    repeat (3) step();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
